coherence_bus_ctrl: RTL and testbench

- Sits directly downstream of the two per-CPU dcaches and upstream of the single-port RAM.
- Arbitrates dcache word requests (dREN/dWEN) between CPU0 and CPU1.
- Runs MSI snoops on the other cache via ccwait/ccsnoopaddr, performs cache-to-cache block transfer with optional RAM update, and issues invalidates (ccinv).
- Instruction-fetch arbitration is out of scope; it lives in a separate block that shares the RAM port upstream of this one.

---
 rtl/coherence_bus_ctrl.sv | 119 +++++++++++
 tb/tb_coherence_bus_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: arbitrates two dcaches onto one RAM port with MSI snooping,
// cache-to-cache block transfer and invalidates.
module coherence_bus_ctrl #(
  parameter int WORD_W  = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  input  logic [1:0]             cctrans,
  input  logic [1:0]             ccwrite,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  output logic [1:0]             ccwait,
  output logic [1:0]             ccinv,
  output logic [1:0][WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
);
  typedef enum logic [2:0] {IDLE, SNOOP, C2C0, C2C1, RAM_RD, RAM_WR, HOLD, INV} state_t;
  state_t state, state_n;
  logic owner, owner_n, prio, prio_n, dirty, dirty_n, hit, hit_n, wmiss, wmiss_n;
  logic other, grant;
  logic [1:0] req;
  assign other = ~owner;
  assign req = dREN | dWEN;
  assign grant = (req == 2'b11) ? prio : req[1];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= RR_INIT;
      dirty <= 1'b0;
      hit   <= 1'b0;
      wmiss <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      prio  <= prio_n;
      dirty <= dirty_n;
      hit   <= hit_n;
      wmiss <= wmiss_n;
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    prio_n = prio;
    dirty_n = dirty;
    hit_n = hit;
    wmiss_n = wmiss;
    dwait = 2'b11;
    dload = '0;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    case (state)
      IDLE: if (|req) begin
        owner_n = grant;
        wmiss_n = dWEN[grant] & ~dREN[grant] & cctrans[grant] & ccwrite[grant];
        state_n = ((dREN[grant] & cctrans[grant] & ~daddr[grant][2]) | wmiss_n) ? SNOOP :
                  (dWEN[grant] & ~cctrans[grant]) ? RAM_WR : RAM_RD;
      end
      SNOOP: begin
        ccwait[other] = 1'b1;
        ccsnoopaddr[other] = daddr[owner];
        hit_n = cctrans[other];
        dirty_n = ccwrite[other];
        state_n = wmiss ? INV : cctrans[other] ? C2C0 : RAM_RD;
      end
      C2C0, C2C1: begin
        // the snooped cache streams its line; a dirty line is also written back to RAM
        ccwait[other] = 1'b1;
        ccinv[other] = (state == C2C1) & ccwrite[owner];
        dload[owner] = dstore[other];
        ramWEN = dirty;
        ramaddr = dirty ? daddr[owner] : '0;
        ramstore = dirty ? dstore[other] : '0;
        if (~dirty | ~ramwait) begin
          dwait = 2'b00;
          state_n = (state == C2C0) ? C2C1 : IDLE;
          prio_n = prio ^ (state == C2C1);
        end
      end
      RAM_RD, RAM_WR: begin
        ramREN = state == RAM_RD;
        ramWEN = state == RAM_WR;
        ramaddr = daddr[owner];
        ramstore = (state == RAM_WR) ? dstore[owner] : '0;
        dload[owner] = (state == RAM_RD) ? ramload : '0;
        if (~ramwait) begin
          dwait[owner] = 1'b0;
          state_n = daddr[owner][2] ? IDLE : HOLD;
          prio_n = prio ^ daddr[owner][2];
        end
      end
      HOLD: state_n = ~(dREN[owner] | dWEN[owner]) ? IDLE :
                      (dWEN[owner] & ~cctrans[owner]) ? RAM_WR : RAM_RD;
      INV: begin
        ccwait[other] = 1'b1;
        ccinv[other] = hit;
        dwait[owner] = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed and random block transactions checked against a
// transaction-level model of arbitration, snooping and RAM timing.
module tb_coherence_bus_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] dREN = '0, dWEN = '0, cctrans = '0, ccwrite = '0;
  logic [1:0][31:0] daddr = '0, dstore = '0;
  logic [1:0] dwait, ccwait, ccinv;
  logic [1:0][31:0] dload, ccsnoopaddr;
  logic ramREN, ramWEN, ramwait = 1'b0;
  logic [31:0] ramaddr, ramstore, ramload = '0;
  int errors = 0, checks = 0;
  logic pri = 1'b0;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // kind: 0 plain read, 1 coherent read, 2 coherent read with write intent, 3 writeback
  task automatic drive(input int c, input logic [1:0] kc, input logic [31:0] a);
    dREN[c] = kc != 2'd3;
    dWEN[c] = kc == 2'd3;
    cctrans[c] = (kc == 2'd1) || (kc == 2'd2);
    ccwrite[c] = kc == 2'd2;
    daddr[c] = a;
    dstore[c] = $urandom;
  endtask

  task automatic blk(input logic [1:0] req, input logic [1:0] k0, input logic [1:0] k1,
                     input logic [31:0] a0, input logic [31:0] a1, input logic two,
                     input logic hit, input logic dirty, input int lat);
    logic w, o, snp, rd;
    logic [1:0] k, one_w, one_o, dw_ok;
    logic [31:0] base, sd, rl;
    int nw, wl;
    w = (req == 2'b11) ? pri : req[1];
    o = ~w;
    k = w ? k1 : k0;
    base = w ? a1 : a0;
    one_w = 2'b01 << w;
    one_o = 2'b01 << o;
    dw_ok = ~one_w;
    snp = ((k == 2'd1) || (k == 2'd2)) && !base[2];
    rd = k != 2'd3;
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramwait = 1'b0;
    if (req[0]) drive(0, k0, a0);
    if (req[1]) drive(1, k1, a1);
    #1;
    chk("idle_dwait", dwait, 2'b11);
    chk("idle_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    if (snp) begin
      chk("snoop_ccwait", ccwait, one_o);
      chk("snoop_addr", ccsnoopaddr[o], base);
      chk("snoop_dwait", dwait, 2'b11);
      chk("snoop_ram", {ramREN, ramWEN}, 2'b00);
      cctrans[o] = hit;
      ccwrite[o] = dirty;
      tick();
    end
    if (snp && hit) begin
      for (int i = 0; i < 2; i++) begin
        sd = $urandom;
        dstore[o] = sd;
        daddr[w] = base + 32'(4 * i);
        wl = dirty ? lat : 0;
        for (int t = 0; t <= wl; t++) begin
          ramwait = t < wl;
          #1;
          chk("c2c_dload", dload[w], sd);
          chk("c2c_ccwait", ccwait, one_o);
          chk("c2c_ram", {ramREN, ramWEN}, {1'b0, dirty});
          if (dirty) begin
            chk("c2c_ramaddr", ramaddr, base + 32'(4 * i));
            chk("c2c_ramstore", ramstore, sd);
          end
          chk("c2c_dwait", dwait, ramwait ? 2'b11 : 2'b00);
          chk("c2c_ccinv", ccinv, (i == 1 && ccwrite[w]) ? one_o : 2'b00);
          tick();
        end
      end
      pri = ~pri;
    end else begin
      nw = (!base[2] && two) ? 2 : 1;
      for (int i = 0; i < nw; i++) begin
        if (i == 1) begin
          daddr[w] = base + 32'd4;
          dstore[w] = $urandom;
          ramwait = 1'b0;
          #1;
          chk("hold_dwait", dwait, 2'b11);
          chk("hold_ram", {ramREN, ramWEN}, 2'b00);
          tick();
        end
        for (int t = 0; t <= lat; t++) begin
          ramwait = t < lat;
          rl = $urandom;
          ramload = rl;
          #1;
          chk("ram_strobe", {ramREN, ramWEN}, rd ? 2'b10 : 2'b01);
          chk("ram_addr", ramaddr, base + 32'(4 * i));
          if (rd) chk("ram_dload", dload[w], rl);
          else chk("ram_store", ramstore, dstore[w]);
          chk("ram_dwait", dwait, ramwait ? 2'b11 : dw_ok);
          chk("ram_ccwait", ccwait, 2'b00);
          tick();
        end
      end
      if (!base[2] && !two) begin
        dREN = '0; dWEN = '0;
        #1;
        chk("drop_dwait", dwait, 2'b11);
        tick();
      end else pri = ~pri;
    end
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramwait = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_cc", {ccwait, ccinv}, 4'b0);
    chk("rst_ram", {ramREN, ramWEN}, 2'b00);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_dload", dload, 64'h0);
    chk("rst_snoopaddr", ccsnoopaddr, 64'h0);
    RST = 1'b0;
    tick();
    repeat (3) blk(2'b11, 2'd0, 2'd0, 32'h600, 32'h700, 1'b1, 1'b0, 1'b0, 0);
    blk(2'b01, 2'd1, 2'd0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    blk(2'b10, 2'd0, 2'd1, 32'h0, 32'h200, 1'b1, 1'b1, 1'b1, 1);
    blk(2'b01, 2'd2, 2'd0, 32'h300, 32'h0, 1'b1, 1'b1, 1'b0, 0);
    blk(2'b10, 2'd0, 2'd3, 32'h0, 32'h800, 1'b0, 1'b0, 1'b0, 3);
    repeat (60)
      blk(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom), $urandom & 32'hFFFF_FFFC,
          $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
          $urandom_range(0, 3));
    // write-miss snoop-invalidate from CPU1, CPU0 holds the line
    dWEN = 2'b10; cctrans = 2'b10; ccwrite = 2'b10; daddr[1] = 32'h440;
    tick();
    chk("wmiss_ccwait", ccwait, 2'b01);
    chk("wmiss_addr", ccsnoopaddr[0], 32'h440);
    cctrans[0] = 1'b1; ccwrite[0] = 1'b0;
    tick();
    dWEN = '0; cctrans = '0; ccwrite = '0;
    #1;
    chk("wmiss_ccinv", ccinv, 2'b01);
    chk("wmiss_ram", {ramREN, ramWEN}, 2'b00);
    tick();
    chk("wmiss_done", {ccinv, ccwait}, 4'b0);
    // reset in the middle of a cache-to-cache transfer
    dREN = 2'b01; cctrans = 2'b01; daddr[0] = 32'h500;
    tick();
    cctrans[1] = 1'b1; dstore[1] = 32'h1234_5678;
    tick();
    chk("c2c0_ccwait", ccwait, 2'b10);
    chk("c2c0_dload", dload[0], 32'h1234_5678);
    RST = 1'b1;
    #1;
    chk("abort_ccwait", ccwait, 2'b00);
    chk("abort_dwait", dwait, 2'b11);
    chk("abort_dload", dload, 64'h0);
    tick();
    chk("abort_ram", {ramREN, ramWEN}, 2'b00);
    RST = 1'b0;
    pri = 1'b0;
    dREN = '0; cctrans = '0;
    blk(2'b01, 2'd0, 2'd0, 32'h900, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    blk(2'b11, 2'd1, 2'd0, 32'hA00, 32'hB00, 1'b1, 1'b1, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
